// File: rtl/prio_arbiter_8.sv
// prio_arbiter_8: 8-way arbiter with a fixed-priority or round-robin winner,
// a single held grant, and a forced release after MAX_HOLD cycles.
// Outputs are registered. A release always passes through IDLE, so there is
// at least one dead cycle between two grants.
module prio_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       rr_mode,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic [2:0] last_id_q, last_id_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win_id;
    logic       rel_done, rel_drop, rel_hold, release_c;

    // Winner selection. Candidates are scanned from lowest to highest
    // priority so that the last match, which is the highest priority, wins.
    // In round-robin mode 3-bit addition wraps index 7 back to 0. Offset 8
    // truncates to 0, which places last_id itself at the lowest priority.
    always_comb begin
        logic [2:0] idx;
        win_id = '0;
        idx    = '0;
        if (!rr_mode) begin
            for (int i = 7; i >= 0; i--) begin
                if (req[i]) win_id = 3'(i);
            end
        end else begin
            for (int k = 8; k >= 1; k--) begin
                idx = last_id_q + 3'(k);
                if (req[idx]) win_id = idx;
            end
        end
    end

    // Release causes. A timeout is reported only when the hold limit is the
    // sole cause of the release.
    always_comb begin
        rel_done  = done;
        rel_drop  = ~req[grant_id_q];
        rel_hold  = (hold_q == HOLD_MAX);
        release_c = rel_done | rel_drop | rel_hold;
    end

    // State register. The same block holds all output and bookkeeping
    // registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= 3'd7;
            hold_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hold_q     <= hold_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state: any request starts a grant, and any release cause ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req != 8'd0) state_d = S_GRANT;
            S_GRANT: if (release_c)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, the hold counter and last_id.
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 8'd0) begin
                    grant_d    = 8'd1 << win_id;
                    grant_id_d = win_id;
                    last_id_d  = win_id;
                    hold_d     = 8'd1;
                end else begin
                    grant_d = '0;
                end
            end
            S_GRANT: begin
                if (release_c) begin
                    grant_d   = '0;
                    hold_d    = '0;
                    timeout_d = rel_hold & ~rel_done & ~rel_drop;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_8.sv
// Testbench for prio_arbiter_8 (MAX_HOLD = 4). A cycle-level reference model
// built from the arbitration rules is checked on every step. It runs directed
// scenarios first, then a randomized stream.
module tb_prio_arbiter_8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst, done, rr_mode;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid, timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state. m_owner is -1 when no grant is held.
    int m_owner, m_hold, m_last, m_gid;
    bit m_to;

    always #5 clk = ~clk;

    prio_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .rr_mode     (rr_mode),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Applies the arbitration rules to the inputs sampled at one clock edge.
    function automatic void model_edge(bit r, logic [7:0] rq, bit dn, bit rr);
        bit by_hold;
        int w;
        if (r) begin
            m_owner = -1; m_hold = 0; m_last = 7; m_gid = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            if (rq != 0) begin
                w = -1;
                if (!rr) begin
                    for (int i = 0; i < 8; i++) if (w < 0 && rq[i]) w = i;
                end else begin
                    for (int k = 1; k <= 8; k++)
                        if (w < 0 && rq[(m_last + k) % 8]) w = (m_last + k) % 8;
                end
                m_owner = w; m_gid = w; m_last = w; m_hold = 1;
            end
        end else begin
            by_hold = (m_hold == MH);
            if (dn || !rq[m_owner] || by_hold) begin
                m_to    = by_hold && !dn && rq[m_owner];
                m_owner = -1;
                m_hold  = 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endfunction

    // Drives the inputs for one edge, advances the model and checks outputs.
    task automatic step(input bit r, input logic [7:0] rq, input bit dn, input bit rr);
        logic [7:0] exp_g;
        rst = r; req = rq; done = dn; rr_mode = rr;
        @(posedge clk);
        model_edge(r, rq, dn, rr);
        #1;
        exp_g = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        chk("grant",       grant,       exp_g);
        chk("grant_id",    grant_id,    m_gid);
        chk("grant_valid", grant_valid, (m_owner >= 0));
        chk("timeout",     timeout,     m_to);
        chk("onehot0",     $onehot0(grant), 1);
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0; rr_mode = 1'b0;
        m_owner = -1; m_hold = 0; m_last = 7; m_gid = 0; m_to = 0;

        // Reset state
        step(1, 8'h00, 0, 0);
        step(1, 8'hFF, 1, 1);
        chk("rst_grant", grant, 8'h00);
        chk("rst_gv", grant_valid, 1'b0);

        // Fixed priority: lowest index wins, re-grant after one idle cycle
        step(0, 8'hA4, 0, 0);
        chk("fp_grant", grant, 8'h04);
        chk("fp_id", grant_id, 3'd2);
        step(0, 8'hA4, 1, 0);
        chk("fp_idle", grant_valid, 1'b0);
        step(0, 8'hA4, 0, 0);
        chk("fp_regrant", grant_id, 3'd2);

        // Round-robin sequence 0..7,0 with done on every grant
        step(1, 8'h00, 0, 1);
        for (int g = 0; g < 9; g++) begin
            step(0, 8'hFF, 0, 1);
            chk("rr_seq", grant_id, g % 8);
            step(0, 8'hFF, 1, 1);
            chk("rr_gap", grant_valid, 1'b0);
        end

        // Timeout: 4 held cycles, one pulse, then re-grant
        step(1, 8'h00, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 8'h08, 0, 0);
            chk("to_held", grant_valid, 1'b1);
        end
        step(0, 8'h08, 0, 0);
        chk("to_pulse", timeout, 1'b1);
        step(0, 8'h08, 0, 0);
        chk("to_regrant", grant_id, 3'd3);
        chk("to_clear", timeout, 1'b0);

        // Requester drop releases without a timeout
        step(1, 8'h00, 0, 0);
        step(0, 8'h20, 0, 0);
        chk("drop_id", grant_id, 3'd5);
        step(0, 8'h00, 0, 0);
        chk("drop_gv", grant_valid, 1'b0);
        chk("drop_to", timeout, 1'b0);

        // Reset mid-grant, then the round-robin search starts at index 0
        step(0, 8'h40, 0, 0);
        chk("rmg_id", grant_id, 3'd6);
        step(1, 8'h40, 0, 0);
        chk("rmg_grant", grant, 8'h00);
        chk("rmg_id0", grant_id, 3'd0);
        step(0, 8'hC1, 0, 1);
        chk("rmg_rr0", grant_id, 3'd0);

        // Done at the hold-limit edge; a new request and a mode change do
        // not move the grant
        step(1, 8'h00, 0, 0);
        step(0, 8'h08, 0, 0);
        step(0, 8'h0A, 0, 1);
        chk("sim_stay", grant_id, 3'd3);
        step(0, 8'h0B, 0, 0);
        step(0, 8'h0A, 0, 1);
        step(0, 8'h0A, 1, 0);
        chk("sim_rel", grant_valid, 1'b0);
        chk("sim_to", timeout, 1'b0);

        // Randomized stream
        begin
            logic [7:0] rq;
            bit rr;
            rq = 8'h00; rr = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(3) == 0) rq = 8'($urandom) & 8'($urandom);
                if ($urandom_range(15) == 0) rr = ~rr;
                step(($urandom_range(99) == 0), rq, ($urandom_range(7) == 0), rr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_8.md
PRIO_ARBITER_8 -- requirements
Module: prio_arbiter_8

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 16, maximum consecutive grant cycles before forced release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 8, request bit per requester 0..7.
REQ-005 The block SHALL have port done, input, 1, the current owner signals release.
REQ-006 The block SHALL have port rr_mode, input, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 The block SHALL have port grant, output, 8, one-hot grant, registered.
REQ-008 The block SHALL have port grant_id, output, 3, binary index of the granted requester, registered.
REQ-009 The block SHALL have port grant_valid, output, 1, high while any grant is held.
REQ-010 The block SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-012 In IDLE with req != 0 at edge N, the block SHALL be in GRANT with outputs valid after edge N; the winner is computed from req and rr_mode sampled at that edge.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with grant = 0, grant_valid = 0 and grant_id unchanged.
REQ-014 With rr_mode = 0 the winner SHALL be the lowest set index of req.
REQ-015 With rr_mode = 1 the winner SHALL be the first set index searching upward from last_id+1 modulo 8 (index 7 wraps to 0).
REQ-016 On every entry into GRANT, last_id SHALL be set to the new grant_id, in both modes.
REQ-017 In GRANT, grant SHALL equal 1 << grant_id, and grant and grant_id SHALL stay constant until release.
REQ-018 A hold counter SHALL load 1 on entry to GRANT, increment each cycle in GRANT and saturate at MAX_HOLD.
REQ-019 Release SHALL occur at the edge where, in GRANT, any of the following holds: done = 1; req[grant_id] = 0; hold counter = MAX_HOLD.
REQ-020 On release the FSM SHALL return to IDLE, so grant_valid is low for at least one cycle between consecutive grants.
REQ-021 timeout SHALL pulse high for exactly the cycle after a release caused only by the hold counter; it SHALL stay low if done = 1 or req[grant_id] = 0 at the same edge.
REQ-022 Changes to req bits other than req[grant_id], and changes to rr_mode, SHALL have no effect while in GRANT.
REQ-023 done asserted while in IDLE SHALL be ignored.
REQ-024 At most one grant bit SHALL ever be high.
REQ-025 grant_valid SHALL equal the OR-reduction of grant.

Reset
REQ-026 With rst = 1 at an edge, the block SHALL force: state = IDLE, grant = 0, grant_id = 0, grant_valid = 0, timeout = 0, hold counter = 0, last_id = 7.
REQ-027 rst SHALL take priority over every other input, including mid-grant; a grant in progress is dropped without a timeout pulse.
REQ-028 The first round-robin search after reset SHALL start at index 0.

Verification
REQ-029 Fixed priority: rr_mode = 0, req = 8'b1010_0100 held -> grant = 8'b0000_0100, grant_id = 2 one cycle later; done pulse -> one idle cycle, then grant_id = 2 again.
REQ-030 Round-robin: rr_mode = 1, req = 8'hFF held, done pulsed each grant -> grant_id sequence 0, 1, ..., 7, 0, with an idle cycle between each grant.
REQ-031 Timeout: MAX_HOLD = 4, req = 8'h08 held, done = 0 -> grant_valid high for 4 cycles, then timeout = 1 for 1 cycle, then re-grant to id 3.
REQ-032 Requester drop: grant to id 5, then req[5] falls -> grant_valid low the next cycle, timeout = 0.
REQ-033 Reset mid-grant: grant_id = 6 held, rst = 1 for one cycle -> all outputs 0; with rr_mode = 1 and req = 8'hC1, the next grant is id 0.
REQ-034 Simultaneous events: at the MAX_HOLD edge, done = 1 -> release with timeout = 0; while a grant is held, a new req bit does not move grant.
